// File: rtl/loader_pkg.sv
// Shared loader definitions: FSM states, length-field size and the WORD/PCL
// defaults that must agree with the instruction memory.
package loader_pkg;

  localparam int LOADER_WORD = 8;
  localparam int LOADER_PCL  = 32;
  localparam int LEN_BYTES   = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE
  } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Byte stream input plus instruction-memory write port of the program loader.
// The slave modport is the loader's view; master is the host/memory side.
interface inst_loader_if
  import loader_pkg::*;
#(
  parameter int WORD = LOADER_WORD,
  parameter int PCL  = LOADER_PCL
);

  logic [WORD-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            mem_we;
  logic [PCL-1:0]  mem_addr;
  logic [WORD-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/inst_loader.sv
// Program loader: start + base address, 4-byte big-endian length, then payload bytes
// written one per memory location. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module inst_loader
  import loader_pkg::*;
#(
  parameter int WORD = LOADER_WORD,
  parameter int PCL  = LOADER_PCL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [PCL-1:0] base_addr,
  input  logic           abort,
  inst_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int               CNT_W    = $clog2(LEN_BYTES);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(LEN_BYTES - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t           state;
  logic [PCL-1:0]   base_q;
  logic [PCL-1:0]   len;
  logic [PCL-1:0]   count;
  logic [CNT_W-1:0] len_cnt;
  logic [PCL-1:0]   len_next;
  logic [PCL-1:0]   count_inc;
  logic             accept;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD-1:0]  chk_acc;
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign len_next  = {len[PCL-WORD-1:0], bus.in_data};
  assign count_inc = count + PCL'(1);

  // Outputs are registered next to the state; abort always wins over the
  // same-cycle transition, but a byte accepted in that cycle is still written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      base_q        <= '0;
      len           <= '0;
      count         <= '0;
      len_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc       <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LEN;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            err          <= 1'b0;
            base_q       <= base_addr;
            len          <= '0;
            count        <= '0;
            len_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc      <= '0;
`endif
          end
        end
        LEN: begin
          if (accept) begin
            len     <= len_next;
            len_cnt <= len_cnt + 1'b1;
          end
          if (abort) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else if (accept && len_cnt == LEN_LAST) begin
            if (len_next == '0) begin
              state        <= TAIL;
              bus.in_ready <= (TAIL == CHK);
              done         <= (TAIL == DONE);
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= base_q + count;
            bus.mem_wdata <= bus.in_data;
            count         <= count_inc;
`ifdef LOADER_CHECKSUM_EN
            chk_acc       <= chk_acc ^ bus.in_data;
`endif
          end
          if (abort) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else if (accept && count_inc == len) begin
            state        <= TAIL;
            bus.in_ready <= (TAIL == CHK);
            done         <= (TAIL == DONE);
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (abort) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else if (accept) begin
            state        <= DONE;
            bus.in_ready <= 1'b0;
            if (bus.in_data == chk_acc) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that writes the byte-wide instruction memory from a serial byte stream. It accepts a start command with a base address, then a 4-byte big-endian length and that many payload bytes over a valid/ready handshake. Each accepted payload byte becomes one memory byte write. The loader holds the processor (busy) while loading and sits between the host/debug link and the instruction memory write port. Byte order matches the fetch side: the byte at the lowest address is the most significant byte of the instruction word.

## Interface
Parameters:
- WORD, 8, width of one memory location and of the stream byte.
- PCL, 32, address width; must equal the instruction memory address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- base_addr  in  PCL  first write address; sampled when start is honoured.
- abort  in  1  cancels a load in progress.
- in_data  in  WORD  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  PCL  write address.
- mem_wdata  out  WORD  write data.
- busy  out  1  load session active; the CPU is stalled while high.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared when the next start is honoured.

## Operation
- A byte transfers only when in_valid && in_ready in the same cycle.
- States and transitions:
  - IDLE → LEN on start.
  - LEN: collects 4 bytes MSB-first into len (PCL bits, truncated). After the 4th byte → DATA, or → CHK/DONE if len == 0.
  - DATA: each accepted byte is written. After the len-th byte → CHK (macro on) or DONE.
  - CHK: one byte accepted → DONE.
  - DONE → IDLE after one cycle.
- in_ready = 1 in LEN, DATA and CHK; 0 in IDLE and DONE.
- Write address is base_addr + count, where count is the number of payload bytes already accepted. Addition is modulo 2^PCL, so the address wraps from 0xFFFFFFFF to 0.
- start while not in IDLE: ignored; the active load is unaffected.
- abort in LEN, DATA or CHK: go to IDLE, set err = 1, no done pulse. A write registered from the same-cycle transfer is still issued. Completed writes remain in memory.
- abort and start in the same cycle in IDLE: start wins; abort is ignored.
- in_valid outside LEN, DATA and CHK: ignored; the data is not consumed.

## Timing
- Reset values: state IDLE; in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0; len and count 0.
- Reset mid-load returns to IDLE immediately (asynchronous); the partial image stays in memory.
- Write latency is 1 cycle. A byte accepted in cycle N produces mem_we = 1 with its address and data in cycle N+1, for exactly one cycle.
- Maximum throughput: one byte per cycle in every accepting state.
- busy is high from the cycle after start is honoured through the DONE cycle inclusive.
- done = 1 in the DONE cycle. Without the checksum, that cycle coincides with the final mem_we.
- Start-to-first-write latency with in_valid held high: 6 cycles (1 enter LEN, 4 length bytes, 1 write register).

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A running XOR of all payload bytes is kept; it is reset to 0 on start.
  - After the payload, the CHK state accepts one trailing byte.
  - If the trailing byte ≠ running XOR, err = 1 and there is no done pulse; DONE is still traversed, and busy drops after it.
  - If it matches, done pulses.
- LOADER_CHECKSUM_EN undefined:
  - The CHK state and XOR register are absent; DATA → DONE directly.
  - err is set only by abort.

## Structure
- Shared package loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, CHK, DONE);
  - LEN_BYTES = 4;
  - the WORD/PCL defaults shared with the instruction memory.
- Single module, no sub-modules; the length shift register, counter and XOR stay inline.

## Test plan
- Normal load: base 0x00000010, len 4, bytes 0x8C 0x01 0x00 0x04 → writes 0x10..0x13 with those bytes on consecutive cycles; done 1 cycle after the last accepted byte; the fetch word at 0x10 reads 0x8C010004.
- Zero length: len 0 → no mem_we; done in the cycle after the 4th length byte (macro off), or after the checksum byte (macro on).
- Wrap and backpressure: base 0xFFFFFFFE, len 4, in_valid toggled every other cycle → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; no byte lost or duplicated.
- Abort after 2 of 8 payload bytes → exactly 2 writes, err = 1, no done, busy low the next cycle; the next start clears err.
- Start while busy, and reset mid-DATA → start ignored; after reset all outputs are 0 and state is IDLE.
- Checksum (macro on): payload 0x12 0x34, checksum 0x26 → done; checksum 0x00 → err = 1, no done.
